// File: rtl/clock_display_scan.sv
// Six-digit common-anode seven-segment scanner for the seconds/minutes/hours
// counters. Snapshots the counter values on iUpdate, splits each into two BCD
// digits, scans one digit per prescaler tick with a blanking window at the
// start of every slot, and drives field blink plus a blinking colon.
//
// State table (scan slot FSM):
//   state      | meaning
//   SLOT_SEC_U | seconds units on oDigit[0]
//   SLOT_SEC_T | seconds tens on oDigit[1]
//   SLOT_MIN_U | minutes units on oDigit[2], colon dot lit in blink phase 0
//   SLOT_MIN_T | minutes tens on oDigit[3]
//   SLOT_HR_U  | hours units on oDigit[4], colon dot lit in blink phase 0
//   SLOT_HR_T  | hours tens on oDigit[5], optionally blanked when zero
module clock_display_scan #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEAD_CYC    = 16,
    parameter int BLINK_TICKS = 250,
    parameter int HR_LZB      = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [5:0] iSec,
    input  logic [5:0] iMin,
    input  logic [4:0] iHour,
    input  logic       iUpdate,
    input  logic [2:0] iBlinkMask,
    output logic [6:0] oSeg,
    output logic       oDp,
    output logic [5:0] oDigit
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [5:0] DIGIT_OFF = 6'h3F;

    generate
        if (DIV < 2) begin : gDivCheck
            $error("clock_display_scan: CLK_HZ/SCAN_HZ must be at least 2");
        end
        if (DEAD_CYC >= DIV) begin : gDeadCheck
            $error("clock_display_scan: DEAD_CYC must be less than CLK_HZ/SCAN_HZ");
        end
    endgenerate

    typedef enum logic [2:0] {
        SLOT_SEC_U = 3'd0,
        SLOT_SEC_T = 3'd1,
        SLOT_MIN_U = 3'd2,
        SLOT_MIN_T = 3'd3,
        SLOT_HR_U  = 3'd4,
        SLOT_HR_T  = 3'd5
    } slotState_t;

    // Tens digit of a 0..63 value by compare chain; no divider needed.
    function automatic logic [2:0] tensOf(input logic [5:0] v);
        logic [2:0] t;
        if (v >= 6'd60)      t = 3'd6;
        else if (v >= 6'd50) t = 3'd5;
        else if (v >= 6'd40) t = 3'd4;
        else if (v >= 6'd30) t = 3'd3;
        else if (v >= 6'd20) t = 3'd2;
        else if (v >= 6'd10) t = 3'd1;
        else                 t = 3'd0;
        return t;
    endfunction

    function automatic logic [3:0] unitsOf(input logic [5:0] v);
        return 4'(v - 6'(tensOf(v)) * 6'd10);
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit is dark.
    function automatic logic [6:0] segOf(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          dead;
    logic [BW-1:0] blinkCnt;
    logic          phase;

    logic [5:0]    snapSec;
    logic [5:0]    snapMin;
    logic [4:0]    snapHour;
    logic [5:0]    hour6;

    slotState_t    slot;
    slotState_t    slotNext;

    logic [3:0]    digitVal;
    logic [5:0]    digitNext;
    logic          fieldBlink;
    logic          lzbBlank;
    logic          blankNext;
    logic          dpNext;

    assign tick  = (prescaler == PRE_LAST);
    assign dead  = (prescaler < DEAD_LIM);
    assign hour6 = {1'b0, snapHour};

    // Slot-rate prescaler, free running from reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Blink phase toggles every BLINK_TICKS scan ticks.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            blinkCnt <= '0;
            phase    <= 1'b0;
        end else if (tick) begin
            if (blinkCnt == BLINK_LAST) begin
                blinkCnt <= '0;
                phase    <= ~phase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
        end
    end

    // Snapshot of the time counters; the display only ever reads these.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            snapSec  <= '0;
            snapMin  <= '0;
            snapHour <= '0;
        end else if (iUpdate) begin
            snapSec  <= iSec;
            snapMin  <= iMin;
            snapHour <= iHour;
        end
    end

    // Scan slot state register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            slot <= SLOT_SEC_U;
        end else begin
            slot <= slotNext;
        end
    end

    // Slot advance on tick, plus the digit, enable and dot for the current slot.
    always_comb begin
        slotNext   = slot;
        digitVal   = 4'd0;
        digitNext  = DIGIT_OFF;
        fieldBlink = 1'b0;
        lzbBlank   = 1'b0;
        dpNext     = 1'b1;
        case (slot)
            SLOT_SEC_U: begin
                if (tick) slotNext = SLOT_SEC_T;
                digitVal   = unitsOf(snapSec);
                digitNext  = 6'b111110;
                fieldBlink = iBlinkMask[0];
            end
            SLOT_SEC_T: begin
                if (tick) slotNext = SLOT_MIN_U;
                digitVal   = {1'b0, tensOf(snapSec)};
                digitNext  = 6'b111101;
                fieldBlink = iBlinkMask[0];
            end
            SLOT_MIN_U: begin
                if (tick) slotNext = SLOT_MIN_T;
                digitVal   = unitsOf(snapMin);
                digitNext  = 6'b111011;
                fieldBlink = iBlinkMask[1];
                dpNext     = phase;
            end
            SLOT_MIN_T: begin
                if (tick) slotNext = SLOT_HR_U;
                digitVal   = {1'b0, tensOf(snapMin)};
                digitNext  = 6'b110111;
                fieldBlink = iBlinkMask[1];
            end
            SLOT_HR_U: begin
                if (tick) slotNext = SLOT_HR_T;
                digitVal   = unitsOf(hour6);
                digitNext  = 6'b101111;
                fieldBlink = iBlinkMask[2];
                dpNext     = phase;
            end
            SLOT_HR_T: begin
                if (tick) slotNext = SLOT_SEC_U;
                digitVal   = {1'b0, tensOf(hour6)};
                digitNext  = 6'b011111;
                fieldBlink = iBlinkMask[2];
                lzbBlank   = (HR_LZB != 0) && (tensOf(hour6) == 3'd0);
            end
            default: begin
                slotNext = SLOT_SEC_U;
            end
        endcase
        blankNext = (fieldBlink && phase) || lzbBlank;
    end

    // Registered drive to the display; everything dark during the dead window.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oSeg   <= SEG_OFF;
            oDp    <= 1'b1;
            oDigit <= DIGIT_OFF;
        end else if (dead) begin
            oSeg   <= SEG_OFF;
            oDp    <= 1'b1;
            oDigit <= DIGIT_OFF;
        end else begin
            oSeg   <= blankNext ? SEG_OFF : segOf(digitVal);
            oDp    <= dpNext;
            oDigit <= digitNext;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: a cycle-level reference model derived from
// the scan arithmetic (slot = tick count mod 6, phase = tick count / blink
// length) checks every cycle, alongside directed frame checks and random input.
module tb_clock_display_scan;

    localparam int CLK_HZ      = 100;
    localparam int SCAN_HZ     = 10;
    localparam int DEAD_CYC    = 2;
    localparam int BLINK_TICKS = 3;
    localparam int DIV         = CLK_HZ / SCAN_HZ;

    logic       clk   = 1'b0;
    logic       rstN  = 1'b0;
    logic [5:0] sec   = '0;
    logic [5:0] min   = '0;
    logic [4:0] hour  = '0;
    logic       upd   = 1'b0;
    logic [2:0] mask  = '0;
    logic [6:0] oSeg;
    logic       oDp;
    logic [5:0] oDigit;

    clock_display_scan #(
        .CLK_HZ(CLK_HZ),
        .SCAN_HZ(SCAN_HZ),
        .DEAD_CYC(DEAD_CYC),
        .BLINK_TICKS(BLINK_TICKS),
        .HR_LZB(1)
    ) dut (
        .iClk(clk),
        .iRst(rstN),
        .iSec(sec),
        .iMin(min),
        .iHour(hour),
        .iUpdate(upd),
        .iBlinkMask(mask),
        .oSeg(oSeg),
        .oDp(oDp),
        .oDigit(oDigit)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    int segTab[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    int k;
    int mSec, mMin, mHour;
    int eDigit, eSeg, eDp;
    int mPre, mIdx, mPh, mD;
    bit mBlank;
    bit checkOn = 1'b0;

    function automatic int refSeg(input int d);
        return (d < 10) ? segTab[d] : 'h7F;
    endfunction

    function automatic int refDigit(input int idx);
        int v;
        v = (idx < 2) ? mSec : (idx < 4) ? mMin : mHour;
        return (idx % 2 == 0) ? v % 10 : v / 10;
    endfunction

    // Model of the display: k counts clock edges since reset release.
    always @(posedge clk) begin
        if (!rstN) begin
            k = 0; mSec = 0; mMin = 0; mHour = 0;
            eDigit = 'h3F; eSeg = 'h7F; eDp = 1;
        end else begin
            mPre = k % DIV;
            mIdx = (k / DIV) % 6;
            mPh  = (k / (DIV * BLINK_TICKS)) % 2;
            if (mPre < DEAD_CYC) begin
                eDigit = 'h3F; eSeg = 'h7F; eDp = 1;
            end else begin
                eDigit = ~(1 << mIdx) & 'h3F;
                mD     = refDigit(mIdx);
                mBlank = (mask[mIdx / 2] && mPh == 1) || (mIdx == 5 && mD == 0);
                eSeg   = mBlank ? 'h7F : refSeg(mD);
                eDp    = ((mIdx == 2 || mIdx == 4) && mPh == 0) ? 0 : 1;
            end
            if (upd) begin
                mSec = sec; mMin = min; mHour = hour;
            end
            k++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkVal("cycDigit", oDigit, rstN ? eDigit : 'h3F);
            checkVal("cycSeg",   oSeg,   rstN ? eSeg   : 'h7F);
            checkVal("cycDp",    oDp,    rstN ? eDp    : 1);
            checkVal("oneHot",   ($countones(~oDigit) <= 1) ? 1 : 0, 1);
        end
    end

    int frameSeg[6];
    int frameCnt[6];
    int frameDead;

    task automatic scanFrame();
        for (int i = 0; i < 6; i++) begin
            frameSeg[i] = -1;
            frameCnt[i] = 0;
        end
        frameDead = 0;
        repeat (6 * DIV) begin
            @(negedge clk);
            if (oDigit == 6'h3F) frameDead++;
            for (int d = 0; d < 6; d++) begin
                if (!oDigit[d]) begin
                    frameSeg[d] = oSeg;
                    frameCnt[d]++;
                end
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int s0, input int s1, input int s2,
                              input int s3, input int s4, input int s5);
        int exp[6];
        exp = '{s0, s1, s2, s3, s4, s5};
        for (int i = 0; i < 6; i++) begin
            checkVal($sformatf("%s_seg%0d", tag, i), frameSeg[i], exp[i]);
        end
    endtask

    task automatic pulseUpdate();
        @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    int newSegTab[6] = '{'h10, 'h12, 'h10, 'h12, 'h30, 'h24};
    int newIdx;
    int guard;
    int minShown, minBlank, otherBlank, dpLowOk, dpLowBad;

    initial begin
        repeat (3) @(negedge clk);
        checkOn = 1'b1;

        // Reset hold
        checkVal("rstDigit", oDigit, 'h3F);
        checkVal("rstSeg",   oSeg,   'h7F);
        checkVal("rstDp",    oDp,    1);

        // Release: two dead cycles, then digit 0 showing "0"
        @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkVal("relDead1", oDigit, 'h3F);
        @(negedge clk);
        checkVal("relDead2", oDigit, 'h3F);
        @(negedge clk);
        checkVal("relFirstDigit", oDigit, 'h3E);
        checkVal("relFirstSeg",   oSeg,   'h40);

        // Snapshot 09:05:42
        sec = 6'd42; min = 6'd5; hour = 5'd9;
        pulseUpdate();
        scanFrame();
        checkFrame("t0905", 'h24, 'h19, 'h12, 'h40, 'h10, 'h7F);
        for (int i = 0; i < 6; i++) checkVal($sformatf("slotOn%0d", i), frameCnt[i], DIV - DEAD_CYC);
        checkVal("frameDead", frameDead, 6 * DEAD_CYC);

        // Live inputs change without a snapshot: display holds
        sec = 6'd59; min = 6'd59; hour = 5'd23;
        scanFrame();
        checkFrame("hold", 'h24, 'h19, 'h12, 'h40, 'h10, 'h7F);

        // Snapshot coincident with a tick
        guard = 0;
        @(negedge clk);
        while (k % DIV != DIV - 1 && guard < 2 * DIV) begin
            @(negedge clk);
            guard++;
        end
        checkVal("tickFound", (k % DIV == DIV - 1) ? 1 : 0, 1);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        newIdx = (k / DIV) % 6;
        repeat (DEAD_CYC + 1) @(negedge clk);
        checkVal("tickUpdDigit", oDigit, ~(1 << newIdx) & 'h3F);
        checkVal("tickUpdSeg",   oSeg,   newSegTab[newIdx]);
        scanFrame();
        checkFrame("t2359", 'h10, 'h12, 'h10, 'h12, 'h30, 'h24);

        // Minute field blink
        mask = 3'b010;
        minShown = 0; minBlank = 0; otherBlank = 0; dpLowOk = 0; dpLowBad = 0;
        repeat (12 * DIV) begin
            @(negedge clk);
            if (oDigit != 6'h3F) begin
                if (!oDigit[2] || !oDigit[3]) begin
                    if (oSeg == 7'h7F) minBlank++; else minShown++;
                end else if (oSeg == 7'h7F) begin
                    otherBlank++;
                end
                if (!oDp) begin
                    if (!oDigit[2] || !oDigit[4]) dpLowOk++; else dpLowBad++;
                end
            end else if (!oDp) begin
                dpLowBad++;
            end
        end
        checkVal("blinkMinShown", (minShown > 0) ? 1 : 0, 1);
        checkVal("blinkMinBlank", (minBlank > 0) ? 1 : 0, 1);
        checkVal("blinkMinSplit", minShown, minBlank);
        checkVal("blinkOther",    otherBlank, 0);
        checkVal("dpLowColon",    (dpLowOk > 0) ? 1 : 0, 1);
        checkVal("dpLowElsewhere", dpLowBad, 0);
        mask = 3'b000;

        // Out-of-range seconds
        sec = 6'd63;
        pulseUpdate();
        scanFrame();
        checkFrame("sec63", 'h30, 'h02, 'h10, 'h12, 'h30, 'h24);

        // Random inputs against the model
        for (int it = 0; it < 25; it++) begin
            sec  = 6'($urandom_range(0, 63));
            min  = 6'($urandom_range(0, 63));
            hour = 5'($urandom_range(0, 31));
            mask = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 40)) begin
                @(negedge clk);
                upd = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        upd  = 1'b0;
        mask = 3'b000;

        // Reset in the middle of the minutes-tens slot
        guard = 0;
        @(negedge clk);
        while (!((k / DIV) % 6 == 3 && k % DIV == 5) && guard < 12 * DIV) begin
            @(negedge clk);
            guard++;
        end
        checkVal("idx3Found", ((k / DIV) % 6 == 3 && k % DIV == 5) ? 1 : 0, 1);
        checkVal("idx3Digit", oDigit, 'h37);
        #2 rstN = 1'b0;
        #1;
        checkVal("midRstDigit", oDigit, 'h3F);
        checkVal("midRstSeg",   oSeg,   'h7F);
        checkVal("midRstDp",    oDp,    1);
        repeat (3) @(negedge clk);
        #2 rstN = 1'b1;
        repeat (DEAD_CYC + 1) @(negedge clk);
        checkVal("restartDigit", oDigit, 'h3E);
        checkVal("restartSeg",   oSeg,   'h40);
        scanFrame();
        checkFrame("afterRst", 'h40, 'h40, 'h40, 'h40, 'h40, 'h7F);

        checkOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
